// File: rtl/cpu_pkg.sv
// Shared constants for the fetch unit: opcodes, widths and state encoding.
// Imported by fetch_mem and cpu_fetch.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 4;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_HALT = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fetch_mem.sv
// Program store: 2**ADDR_W words, one synchronous write port and one
// combinational read port. Contents are never reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fetch_mem
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch sequencer: IDLE/RUN/DONE FSM issuing program words.
// Ports: clk, clr (async high), load_en/load_addr/load_data (program write),
//   start, stall in; code, code_valid, pc, busy, done out.
// Optional macro FETCH_LOOP_EN: pc wraps to 0 instead of ending the run.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 4,
  parameter logic [OP_W-1:0]    HALT_OP  = OP_HALT,
  parameter logic [INSTR_W-1:0] NOP_CODE = 16'h0000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               stall,
  output logic [INSTR_W-1:0] code,
  output logic               code_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] code_q, code_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [INSTR_W-1:0] rd_word;
  logic               mem_we;
  logic               is_halt;

  assign mem_we  = load_en && (state_q != ST_RUN);
  assign is_halt = rd_word[INSTR_W-1 -: OP_W] == HALT_OP;

  fetch_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc_q),
    .rdata(rd_word)
  );

`ifndef FETCH_LOOP_EN
  logic at_end;
  assign at_end = &pc_q;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    code_d  = code_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (last_q || is_halt) begin
            state_d = ST_DONE;
            code_d  = NOP_CODE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            code_d  = rd_word;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
`ifndef FETCH_LOOP_EN
            // Top word issued: park pc there and end next edge.
            if (at_end) begin
              pc_d   = pc_q;
              last_d = 1'b1;
            end
`endif
          end
        end
      end
      default: begin
        // A write in the same cycle wins over start.
        if (start && !load_en) begin
          state_d = ST_RUN;
          pc_d    = '0;
          code_d  = NOP_CODE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      code_q  <= NOP_CODE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign pc         = pc_q;
  assign busy       = state_q == ST_RUN;
  assign done       = state_q == ST_DONE;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: load, run, stall, halt, clr, wrap.
// Inputs change and outputs are checked on the falling edge.
module tb_cpu_fetch;

  logic        clk;
  logic        clr;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        stall;
  logic [15:0] code;
  logic        code_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  logic [15:0] prog [5];
  logic [15:0] w16  [16];

  cpu_fetch dut (
    .clk       (clk),
    .clr       (clr),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .stall     (stall),
    .code      (code),
    .code_valid(code_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a,
                      input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    clr       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    start     = 1'b0;
    stall     = 1'b0;
    prog[0] = 16'h1000;
    prog[1] = 16'h1101;
    prog[2] = 16'h1203;
    prog[3] = 16'h1303;
    prog[4] = 16'h3023;
    for (int i = 0; i < 16; i++) begin
      w16[i] = {(i == 0) ? 4'hf : 4'(i),
                4'(i), 8'h5a};
    end

    // reset state
    tick();
    tick();
    chk("rst_code", code, 16'h0000);
    chk("rst_valid", {15'd0, code_valid}, 16'd0);
    chk("rst_pc", {12'd0, pc}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    clr = 1'b0;
    tick();

    // basic run ending on halt at 5
    for (int i = 0; i < 5; i++) load(4'(i), prog[i]);
    load(4'd5, 16'h0000);
    go();
    chk("run_busy", {15'd0, busy}, 16'd1);
    chk("run_v0", {15'd0, code_valid}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("run_code%0d", i), code, prog[i]);
      chk($sformatf("run_val%0d", i),
          {15'd0, code_valid}, 16'd1);
      chk($sformatf("run_pc%0d", i),
          {12'd0, pc}, 16'(i + 1));
    end
    tick();
    chk("halt_valid", {15'd0, code_valid}, 16'd0);
    chk("halt_code", code, 16'h0000);
    chk("halt_done", {15'd0, done}, 16'd1);
    chk("halt_busy", {15'd0, busy}, 16'd0);
    chk("halt_pc", {12'd0, pc}, 16'd5);

    // stall two cycles on 1203
    go();
    tick();
    tick();
    tick();
    chk("st_code", code, 16'h1203);
    chk("st_pc", {12'd0, pc}, 16'd3);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_hold", code, 16'h1203);
      chk("st_hval", {15'd0, code_valid}, 16'd1);
      chk("st_hpc", {12'd0, pc}, 16'd3);
    end
    stall = 1'b0;
    tick();
    chk("st_next", code, 16'h1303);
    tick();
    chk("st_last", code, 16'h3023);
    tick();
    chk("st_done", {15'd0, done}, 16'd1);
    chk("st_dpc", {12'd0, pc}, 16'd5);

    // write during run is ignored
    go();
    tick();
    load_en   = 1'b1;
    load_addr = 4'd2;
    load_data = 16'hbeef;
    tick();
    load_en   = 1'b0;
    chk("wr_run1", code, 16'h1101);
    tick();
    chk("wr_run2", code, 16'h1203);
    tick();
    tick();
    tick();
    chk("wr_done", {15'd0, done}, 16'd1);

    // async clr mid-run, rerun confirms mem[2]
    go();
    tick();
    tick();
    tick();
    chk("rr_code2", code, 16'h1203);
    tick();
    chk("clr_pre", code, 16'h1303);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_code", code, 16'h0000);
    chk("clr_valid", {15'd0, code_valid}, 16'd0);
    chk("clr_pc", {12'd0, pc}, 16'd0);
    chk("clr_busy", {15'd0, busy}, 16'd0);
    tick();
    clr = 1'b0;
    tick();
    go();
    tick();
    chk("clr_rerun", code, 16'h1000);
    pulse_clr();

    // load and start together: write only
    load(4'd6, 16'h0000);
    load_en   = 1'b1;
    start     = 1'b1;
    load_addr = 4'd5;
    load_data = 16'h2abc;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    chk("ls_busy", {15'd0, busy}, 16'd0);
    chk("ls_valid", {15'd0, code_valid}, 16'd0);
    tick();
    chk("ls_busy2", {15'd0, busy}, 16'd0);
    go();
    for (int i = 0; i < 5; i++) tick();
    chk("ls_w4", code, 16'h3023);
    tick();
    chk("ls_w5", code, 16'h2abc);
    tick();
    chk("ls_done", {15'd0, done}, 16'd1);
    chk("ls_pc", {12'd0, pc}, 16'd6);

    // all 16 words non-halt
    for (int i = 0; i < 16; i++) load(4'(i), w16[i]);
    go();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("w16_%0d", i), code, w16[i]);
    end
`ifdef FETCH_LOOP_EN
    chk("wrap_pc", {12'd0, pc}, 16'd0);
    tick();
    chk("wrap_code", code, w16[0]);
    chk("wrap_busy", {15'd0, busy}, 16'd1);
    pulse_clr();
`else
    chk("end_pc", {12'd0, pc}, 16'd15);
    tick();
    chk("end_done", {15'd0, done}, 16'd1);
    chk("end_valid", {15'd0, code_valid}, 16'd0);
    chk("end_code", code, 16'h0000);
    chk("end_pc2", {12'd0, pc}, 16'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
